cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Converts single-cycle 256-bit cache-line requests from the cache arbiter into four-beat 64-bit bursts on the physical memory port, and returns read lines as one 256-bit word. It sits between the arbiter's memory-side port and physical memory, acting as the responder to the arbiter's `mem_read`/`mem_write` handshake. It also acts as the initiator of the burst protocol toward memory.

## Interface
Parameters:
- none (line width 256, beat width 64, beats per line 4 are fixed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  line read request from arbiter, held until mem_resp
- mem_write  in  1  line write request from arbiter, held until mem_resp
- mem_address  in  32  line address
- mem_wdata  in  256  write line
- mem_rdata  out  256  read line, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  burst read request to memory
- pmem_write  out  1  burst write request to memory
- pmem_address  out  32  burst address, constant for the whole burst
- pmem_wdata  out  64  current write beat
- pmem_rdata  in  64  current read beat, valid when pmem_resp=1
- pmem_resp  in  1  beat accepted/delivered this cycle

## Operation
- Registers:
  - state ∈ {IDLE, READ, WRITE, DONE}
  - 2-bit beat counter `beat`
  - 256-bit line buffer `line`
  - 32-bit address latch `addr`
- IDLE:
  - mem_write=1: latch addr←mem_address, line←mem_wdata, beat←0, go WRITE. Write wins if mem_read and mem_write are both high.
  - mem_read=1 only: latch addr, beat←0, go READ.
  - Otherwise stay in IDLE.
- READ:
  - pmem_read=1.
  - Each cycle with pmem_resp=1: line[64*beat+63 : 64*beat]←pmem_rdata, beat←beat+1.
  - The beat at beat=3 moves to DONE and beat wraps to 0.
  - Cycles with pmem_resp=0 are stalls; nothing changes.
- WRITE:
  - pmem_write=1, pmem_wdata=line[64*beat+63 : 64*beat].
  - Each cycle with pmem_resp=1 advances beat; the beat at beat=3 moves to DONE.
- DONE:
  - mem_resp=1 for exactly this cycle; mem_rdata=line.
  - Unconditionally return to IDLE next cycle.
- pmem_address=addr in READ and WRITE. pmem_read and pmem_write are never both high.
- mem_rdata is driven from `line` in every state and is guaranteed only in DONE.
- mem_address, mem_wdata, mem_read and mem_write are ignored outside IDLE. Changes to them mid-burst have no effect.

## Timing
- Reset values:
  - state=IDLE, beat=0, line=0, addr=0
  - mem_resp=0, pmem_read=0, pmem_write=0
  - pmem_address=0, pmem_wdata=0, mem_rdata=0
- Acceptance cycle: the request is sampled in IDLE at edge T. pmem_read or pmem_write is high from cycle T+1.
- Minimum latency: 5 cycles from the accepting edge to mem_resp. That is 4 back-to-back pmem_resp beats in cycles T+1 to T+4, then mem_resp in T+5.
- Each stall cycle (pmem_resp=0) adds one cycle.
- After DONE there is one mandatory IDLE cycle. A request still held in that cycle is accepted as a new transaction.
  - The arbiter drops or switches its request on mem_resp, so no duplicate is issued.
- Reset mid-burst: at the next edge the block returns to IDLE with all outputs at reset values. The partial burst is abandoned and no mem_resp is issued.
- pmem_resp arriving in IDLE or DONE is ignored.

## Configuration
- `CACHELINE_ADAPTOR_ALIGN_EN`:
  - Defined: pmem_address = {addr[31:5], 5'b0}, i.e. always 32-byte line aligned.
  - Undefined: pmem_address = addr unmodified; upstream is responsible for alignment.

## Test plan
- Read, no stalls:
  - Stimulus: mem_read=1, mem_address=0x0000_1040; pmem_resp=1 for 4 cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: mem_resp in the 5th cycle after acceptance; mem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; pmem_address=0x0000_1040 throughout.
- Write with stalls:
  - Stimulus: mem_write=1, mem_wdata=0xDDDD..CCCC..BBBB..AAAA; pmem_resp pattern 1,0,1,0,0,1,1.
  - Required: pmem_wdata steps AAAA→BBBB→CCCC→DDDD, changing only after each resp=1 cycle; mem_resp exactly one cycle after the 4th accepted beat; pmem_write low afterward.
- Simultaneous mem_read=1 and mem_write=1 in IDLE:
  - Required: WRITE burst (pmem_write=1, pmem_read=0).
- Reset asserted after 2 read beats:
  - Required: next cycle pmem_read=0, mem_resp=0, mem_rdata=0; a following read completes normally in 5 cycles.
- Alignment, mem_address=0x0000_105C:
  - Required: with `CACHELINE_ADAPTOR_ALIGN_EN`, pmem_address=0x0000_1040; without it, 0x0000_105C.
- Back-to-back requests (mem_read held through mem_resp, then a new read):
  - Required: exactly one IDLE cycle between bursts; the second burst starts the cycle after that IDLE.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit line requests <-> four 64-bit pmem bursts.
// Ports: clk/rst, mem_* (arbiter side), pmem_* (memory side); CACHELINE_ADAPTOR_ALIGN_EN aligns pmem_address.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [63:0]  pmem_wdata,
  input  logic [63:0]  pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [255:0]   line_q, line_d;
  logic [31:0]    addr_q, addr_d;
  logic [7:0]     beat_lsb;
  logic           busy;
  logic [31:0]    addr_out;

  assign beat_lsb = {beat_q, 6'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // write has priority when both requests are raised
        if (mem_write) begin
          addr_d  = mem_address;
          line_d  = mem_wdata;
          beat_d  = 2'd0;
          state_d = WRITE;
        end else if (mem_read) begin
          addr_d  = mem_address;
          beat_d  = 2'd0;
          state_d = READ;
        end
      end
      READ: begin
        if (pmem_resp) begin
          line_d[beat_lsb +: 64] = pmem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_out = {addr_q[31:5], 5'b0};
`else
  assign addr_out = addr_q;
`endif

  assign pmem_read    = (state_q == READ);
  assign pmem_write   = (state_q == WRITE);
  assign mem_resp     = (state_q == DONE);
  assign busy         = pmem_read | pmem_write;
  assign mem_rdata    = line_q;
  assign pmem_address = busy ? addr_out : 32'd0;
  assign pmem_wdata   = pmem_write ? line_q[beat_lsb +: 64] : 64'd0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench with a behavioural memory model.
// Driver issues line requests, responder models pmem, monitor checks.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  paddr;
    logic [255:0] line;
    int           issue_cyc;
  } txn_t;

  txn_t         exp_q[$];
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] phys_mem [logic [31:0]];
  bit           pat_q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           k = 0;
  int           last4_cyc = -100;
  int           last_resp_cyc = -100;
  int           es;
  bit           r_go;
  bit           busy_prev = 0;
  bit           resp_prev = 0;
  logic [255:0] wbuf = '0;
  logic [255:0] resp_line;
  txn_t         mt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] init_line(logic [31:0] a);
    return {a ^ 32'h8888_8888, a ^ 32'h7777_7777, a ^ 32'h6666_6666,
            a ^ 32'h5555_5555, a ^ 32'h4444_4444, a ^ 32'h3333_3333,
            a ^ 32'h2222_2222, a ^ 32'h1111_1111};
  endfunction

  function automatic logic [255:0] ref_get(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] phys_get(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  function automatic logic [31:0] exp_paddr(logic [31:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    return {a[31:5], 5'b0};
`else
    return a;
`endif
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // pmem responder: a memory holding whole lines, served beat by beat
  always @(negedge clk) begin
    if (rst) begin
      k = 0;
      pmem_resp = 1'b0;
    end else if (pmem_read | pmem_write) begin
      if (pat_q.size() > 0) r_go = pat_q.pop_front();
      else r_go = ($urandom_range(0, 3) != 0);
      pmem_resp = r_go;
      pmem_rdata = {$urandom, $urandom};
      if (r_go) begin
        if (pmem_read) begin
          resp_line = phys_get(pmem_address);
          pmem_rdata = resp_line[64*k +: 64];
        end else begin
          wbuf[64*k +: 64] = pmem_wdata;
        end
        if (k == 3) begin
          if (pmem_write) phys_mem[pmem_address] = wbuf;
          last4_cyc = cyc;
          k = 0;
        end else begin
          k++;
        end
      end
    end else begin
      pmem_resp = 1'($urandom_range(0, 1));
      pmem_rdata = {$urandom, $urandom};
    end
  end

  // monitor: burst start, address, completion and returned data
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 0;
      resp_prev = 0;
    end else begin
      if (pmem_read | pmem_write) begin
        chk("rd_wr_exclusive", pmem_read & pmem_write, 0);
        if (!busy_prev) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_burst at cycle %0d", cyc);
          end else begin
            es = (exp_q[0].issue_cyc > last_resp_cyc + 1) ?
                 exp_q[0].issue_cyc : last_resp_cyc + 1;
            chk("burst_start_cycle", cyc, es + 1);
            chk("burst_kind_write", pmem_write, exp_q[0].wr);
          end
        end
        if (exp_q.size() > 0)
          chk("pmem_address", pmem_address, exp_q[0].paddr);
      end
      if (mem_resp) begin
        chk("resp_single_cycle", resp_prev, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_resp at cycle %0d", cyc);
        end else begin
          mt = exp_q.pop_front();
          chk("resp_after_last_beat", cyc, last4_cyc + 1);
          if (mt.wr) chk("write_line", phys_get(mt.paddr), mt.line);
          else chk("read_line", mem_rdata, mt.line);
        end
        last_resp_cyc = cyc;
      end
      busy_prev = pmem_read | pmem_write;
      resp_prev = mem_resp;
    end
  end

  task automatic issue(bit rd, bit wr, logic [31:0] a, logic [255:0] wd);
    txn_t t;
    bit   done;
    t.wr = wr;
    t.paddr = exp_paddr(a);
    if (wr) begin
      t.line = wd;
      ref_mem[t.paddr] = wd;
    end else begin
      t.line = ref_get(t.paddr);
    end
    t.issue_cyc = cyc;
    exp_q.push_back(t);
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_wdata = wd;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        done = 1;
      end else if (pmem_read | pmem_write) begin
        mem_address = $urandom;
        mem_wdata = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout addr %h", a);
    end
  endtask

  task automatic idle(int n);
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t         t;
    logic [255:0] l;
    logic [31:0]  a;
    int           kind;
    bit           hit;

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    rst = 1'b0;
    idle(1);

    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    ref_mem[32'h0000_1040] = l;
    phys_mem[32'h0000_1040] = l;
    pat_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    issue(1, 0, 32'h0000_1040, '0);
    idle(1);

    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    issue(0, 1, 32'h0000_2080, l);
    idle(1);
    chk("write_low_after", pmem_write, 0);
    chk("write_phys", phys_get(32'h0000_2080), l);

    issue(1, 1, 32'h0000_3000, {8{32'h5A5A_1234}});
    idle(1);

    issue(1, 0, 32'h0000_105C, '0);
    idle(2);

    t.wr = 0;
    t.paddr = exp_paddr(32'h0000_1100);
    t.line = ref_get(t.paddr);
    t.issue_cyc = cyc;
    exp_q.push_back(t);
    pat_q = '{1'b1, 1'b1};
    mem_read = 1'b1;
    mem_address = 32'h0000_1100;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (k == 2) hit = 1;
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL abort_wait: two beats never taken");
    end
    rst = 1'b1;
    mem_read = 1'b0;
    t = exp_q.pop_back();
    pat_q.delete();
    @(posedge clk);
    #1;
    chk("abort_pmem_read", pmem_read, 0);
    chk("abort_mem_resp", mem_resp, 0);
    chk("abort_mem_rdata", mem_rdata, 0);
    chk("abort_pmem_address", pmem_address, 0);
    rst = 1'b0;
    idle(1);
    pat_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    issue(1, 0, 32'h0000_1040, '0);
    idle(1);

    issue(1, 0, 32'h0000_1040, '0);
    issue(1, 0, 32'h0000_2080, '0);
    idle(1);

    repeat (60) begin
      kind = $urandom_range(0, 3);
      a = 32'h0000_4000 + ($urandom_range(0, 7) << 5);
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(0, 31);
      l = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      issue(kind != 1, kind != 0, a, l);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
